add_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one registered 4-bit adder between NREQ requesters.
- The adder computes sum <= a+b with one clock of latency.
- Each requester uses a valid/ready operand channel and a valid/ready result channel.
- The block drives the adder's operand inputs, waits one cycle for the registered sum, and returns the sum to the requester that issued it.

---
 rtl/add_share_arb_if.sv | 24 ++
 rtl/add_share_arb.sv | 102 ++++++++++
 tb/tb_add_share_arb.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_share_arb_if.sv
// Requester-side operand and result channels for add_share_arb.
// Master is the requester population, slave is the arbiter.
interface add_share_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH:0]        rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one registered adder
// between NREQ requesters (IDLE -> EXEC -> RESP).
module add_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  add_share_arb_if.slave   bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH+1:0] add_sum,
  output logic             busy,
  output logic [7:0]       done_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    ptr_nxt;
  logic             any;
  logic [NREQ-1:0]  rsp_vld;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             unused_msb;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    logic [PW:0] idx;
    idx   = '0;
    grant = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (bus.req_valid[idx]) begin
        grant = idx[PW-1:0];
        any   = 1'b1;
      end
    end
  end

  assign sel_a = bus.req_a[grant*WIDTH +: WIDTH];
  assign sel_b = bus.req_b[grant*WIDTH +: WIDTH];

  assign ptr_nxt = (owner == PW'(NREQ - 1))
                 ? '0 : owner + 1'b1;

  assign bus.req_ready =
    (rst_n && state == IDLE && any)
    ? (NREQ'(1) << grant) : '0;

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_sum   = (state == RESP)
                       ? add_sum[WIDTH:0] : '0;
  assign busy          = (state != IDLE);
  assign unused_msb    = add_sum[WIDTH+1];

  // sequencer: grant, wait for adder, hold result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      add_a    <= '0;
      add_b    <= '0;
      rsp_vld  <= '0;
      done_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            add_a <= sel_a;
            add_b <= sel_b;
            owner <= grant;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_vld <= NREQ'(1) << owner;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) begin
            rsp_vld  <= '0;
            ptr      <= ptr_nxt;
            done_cnt <= done_cnt + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb against a
// transaction-level round-robin model.
module tb_add_share_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [5:0] add_sum;
  logic       busy;
  logic [7:0] done_cnt;

  int checks;
  int fails;
  int mptr;
  logic [7:0] mdone;

  add_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  add_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  // external registered adder
  always_ff @(posedge clk)
    add_sum <= {2'b0, add_a} + {2'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr(input int p,
                            input logic [3:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ] === 1'b1)
        return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    mdone = 8'd0;
  endtask

  // one full operation; got = observed grant vector
  task automatic run_op(input logic [3:0] mask,
                        input logic [15:0] av_in,
                        input logic [15:0] bv_in,
                        input int stall,
                        output logic [3:0] got);
    logic [15:0] av;
    logic [15:0] bv;
    logic [3:0]  oh;
    logic [3:0]  ea;
    logic [3:0]  eb;
    logic [4:0]  es;
    int g;
    av = av_in;
    bv = bv_in;
    for (int i = 0; i < NREQ; i++)
      if (!mask[i]) begin
        av[i*4 +: 4] = 4'bx;
        bv[i*4 +: 4] = 4'bx;
      end
    g  = rr(mptr, mask);
    oh = 4'(1 << g);
    ea = av_in[g*4 +: 4];
    eb = bv_in[g*4 +: 4];
    es = {1'b0, ea} + {1'b0, eb};
    bus.req_valid = mask;
    bus.req_a = av;
    bus.req_b = bv;
    bus.rsp_ready = '0;
    #1;
    got = bus.req_ready;
    checks++;
    if (bus.req_ready !== oh) begin
      fails++;
      $display("FAIL grant got=%b exp=%b",
               bus.req_ready, oh);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[g] = 1'b0;
    #1;
    checks++;
    if (add_a !== ea || add_b !== eb) begin
      fails++;
      $display("FAIL operands got=%h,%h exp=%h,%h",
               add_a, add_b, ea, eb);
    end
    checks++;
    if (bus.req_ready !== 4'b0 || busy !== 1'b1 ||
        bus.rsp_valid !== 4'b0) begin
      fails++;
      $display("FAIL exec got=%b/%b/%b exp=0000/1/0000",
               bus.req_ready, busy, bus.rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = 4'($urandom) & ~oh;
      #1;
      checks++;
      if (bus.rsp_valid !== oh ||
          bus.rsp_sum !== es) begin
        fails++;
        $display("FAIL stall_rsp got=%b/%h exp=%b/%h",
                 bus.rsp_valid, bus.rsp_sum, oh, es);
      end
      checks++;
      if (add_a !== ea || add_b !== eb ||
          bus.req_ready !== 4'b0 ||
          done_cnt !== mdone) begin
        fails++;
        $display("FAIL stall_hold got=%h,%h,%b,%0d exp=%h,%h,0000,%0d",
                 add_a, add_b, bus.req_ready, done_cnt,
                 ea, eb, mdone);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.rsp_ready = oh | 4'($urandom);
    #1;
    checks++;
    if (bus.rsp_valid !== oh ||
        bus.rsp_sum !== es) begin
      fails++;
      $display("FAIL rsp got=%b/%h exp=%b/%h",
               bus.rsp_valid, bus.rsp_sum, oh, es);
    end
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = '0;
    mdone = mdone + 8'd1;
    mptr  = (g + 1) % NREQ;
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0 || busy !== 1'b0 ||
        done_cnt !== mdone) begin
      fails++;
      $display("FAIL after got=%b/%b/%0d exp=0000/0/%0d",
               bus.rsp_valid, busy, done_cnt, mdone);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 4'b0 ||
        bus.req_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl got=%b/%b/%b exp=0/0000/0000",
               busy, bus.rsp_valid, bus.req_ready);
    end
    checks++;
    if (add_a !== 4'h0 || add_b !== 4'h0 ||
        done_cnt !== 8'd0 || bus.rsp_sum !== 5'd0) begin
      fails++;
      $display("FAIL reset_data got=%h,%h,%0d,%h exp=0,0,0,0",
               add_a, add_b, done_cnt, bus.rsp_sum);
    end
  endtask

  task automatic test_single();
    logic [3:0] got;
    do_reset();
    run_op(4'b0001, 16'h0001, 16'h0005, 0, got);
    checks++;
    if (done_cnt !== 8'd1) begin
      fails++;
      $display("FAIL single_cnt got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] got;
    logic [3:0] m;
    do_reset();
    m = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      run_op(m, 16'h5431, 16'h6845, 0, got);
      checks++;
      if (got !== 4'(1 << i)) begin
        fails++;
        $display("FAIL all4_order got=%b exp=%b",
                 got, 4'(1 << i));
      end
      m[i] = 1'b0;
    end
    checks++;
    if (done_cnt !== 8'd4) begin
      fails++;
      $display("FAIL all4_cnt got=%0d exp=4", done_cnt);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] got;
    int order [6] = '{3, 0, 1, 3, 0, 1};
    do_reset();
    run_op(4'b0010, 16'h0020, 16'h0030, 0, got);
    for (int i = 0; i < 6; i++) begin
      run_op(4'b1011, 16'($urandom),
             16'($urandom), 0, got);
      checks++;
      if (got !== 4'(1 << order[i])) begin
        fails++;
        $display("FAIL fair_order got=%b exp=%b",
                 got, 4'(1 << order[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got;
    run_op(4'b0110, 16'h0970, 16'h0c20, 5, got);
    run_op(4'b1000, 16'hf000, 16'hf000, 5, got);
  endtask

  task automatic test_width();
    logic [3:0] got;
    run_op(4'b0100, 16'h0f00, 16'h0f00, 1, got);
    run_op(4'b1111, 16'hffff, 16'hffff, 0, got);
  endtask

  task automatic test_wrap();
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 256; i++)
      run_op(4'($urandom_range(1, 15)),
             16'($urandom), 16'($urandom),
             $urandom_range(0, 2), got);
    checks++;
    if (done_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wrap got=%0d exp=0", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    do_reset();
    run_op(4'b0001, 16'h0002, 16'h0003, 0, got);
    bus.req_valid = 4'b0100;
    bus.req_a = 16'h0300;
    bus.req_b = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_exec got=%b exp=1", busy);
    end
    bus.req_valid = 4'b0010;
    bus.req_a = 16'h00a0;
    bus.req_b = 16'h0010;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    mdone = 8'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 4'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 ||
        done_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_rst got=%b/%b/%h/%h/%0d exp=0/0000/0/0/0",
               busy, bus.rsp_valid, add_a, add_b, done_cnt);
    end
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL mid_pend got=%b exp=0010",
               bus.req_ready);
    end
    run_op(4'b0010, 16'h00a0, 16'h0010, 0, got);
    bus.req_valid = 4'b0001;
    bus.req_a = 16'h0007;
    bus.req_b = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0001 ||
        bus.rsp_sum !== 5'd15) begin
      fails++;
      $display("FAIL mid_resp got=%b/%h exp=0001/0f",
               bus.rsp_valid, bus.rsp_sum);
    end
    rst_n = 1'b0;
    bus.rsp_ready = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 4'b0000;
    mptr  = 0;
    mdone = 8'd0;
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0 || done_cnt !== 8'd0 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL resp_rst got=%b/%0d/%b exp=0000/0/0",
               bus.rsp_valid, done_cnt, busy);
    end
    run_op(4'b0011, 16'h0045, 16'h0021, 0, got);
    checks++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL ptr_rst got=%b exp=0001", got);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    mptr   = 0;
    mdone  = 8'd0;
    rst_n  = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_width();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
